// File: rtl/xor_share_sched.sv
// Round-robin scheduler that time-shares one external 2-input XOR cell among NREQ requesters,
// streaming each granted operand pair LSB-first and returning the assembled W-bit result.
module xor_share_sched #(
    parameter int unsigned NREQ = 4,
    parameter int unsigned W    = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] op_a,
    input  logic [NREQ*W-1:0] op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   done,
    output logic [W-1:0]      result,
    output logic              busy,
    output logic              xa,
    output logic              xb,
    input  logic              xy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int unsigned CW = $clog2(W);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [PW-1:0] r_ptr;
    logic [PW-1:0] r_k;
    logic [PW-1:0] w_win;
    logic [PW-1:0] w_idx;
    logic          w_found;
    logic          w_last;
    logic [NREQ-1:0] r_gnt;
    logic [W-1:0]  r_sh_a;
    logic [W-1:0]  r_sh_b;
    logic [W-1:0]  r_res;
    logic [W-1:0]  r_result;
    logic [CW-1:0] r_cnt;

    // Search ptr+1, ptr+2, ... modulo NREQ; the first asserted request wins.
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_idx   = '0;
        for (int unsigned i = 1; i <= NREQ; i++) begin
            w_idx = PW'((32'(r_ptr) + i) % NREQ);
            if (!w_found && req[w_idx]) begin
                w_found = 1'b1;
                w_win   = w_idx;
            end
        end
    end

    assign w_last = (r_cnt == CW'(W - 1));

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_found) w_state_nxt = SHIFT;
            SHIFT:   if (w_last) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr    <= PW'(NREQ - 1);
            r_k      <= '0;
            r_gnt    <= '0;
            r_sh_a   <= '0;
            r_sh_b   <= '0;
            r_res    <= '0;
            r_result <= '0;
            r_cnt    <= '0;
        end else begin
            unique case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_k    <= w_win;
                        r_gnt  <= NREQ'(1) << w_win;
                        r_sh_a <= op_a[32'(w_win)*W +: W];
                        r_sh_b <= op_b[32'(w_win)*W +: W];
                        r_cnt  <= '0;
                    end
                end
                SHIFT: begin
                    r_res  <= {xy, r_res[W-1:1]};
                    r_sh_a <= r_sh_a >> 1;
                    r_sh_b <= r_sh_b >> 1;
                    r_cnt  <= r_cnt + 1'b1;
                    // Capture on the final shift edge so result is visible together with done.
                    if (w_last) r_result <= {xy, r_res[W-1:1]};
                end
                DONE: begin
                    r_ptr <= r_k;
                    r_gnt <= '0;
                end
                default: ;
            endcase
        end
    end

    assign gnt    = r_gnt;
    assign done   = (r_state == DONE) ? r_gnt : '0;
    assign result = r_result;
    assign busy   = (r_state != IDLE);
    assign xa     = (r_state == SHIFT) & r_sh_a[0];
    assign xb     = (r_state == SHIFT) & r_sh_b[0];

endmodule

// File: tb/tb_xor_share_sched.sv
// Self-checking bench for xor_share_sched: vector table, corner-case sequences and a
// scoreboard that predicts each grant and result from the requests and operands it drove.
module tb_xor_share_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NREQ-1:0]   req = '0;
    logic [NREQ*W-1:0] op_a = '0;
    logic [NREQ*W-1:0] op_b = '0;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   done;
    logic [W-1:0]      result;
    logic              busy;
    logic              xa;
    logic              xb;
    logic              xy;
    logic              fault = 1'b0;

    assign xy = fault ? 1'b0 : (xa ^ xb);

    xor_share_sched #(.NREQ(NREQ), .W(W)) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .op_a   (op_a),
        .op_b   (op_b),
        .gnt    (gnt),
        .done   (done),
        .result (result),
        .busy   (busy),
        .xa     (xa),
        .xb     (xb),
        .xy     (xy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    typedef struct {
        int         k;
        logic [7:0] exp;
    } sb_t;

    sb_t               sbq[$];
    int                gorder[$];
    int                gtime[$];
    int                cycle  = 0;
    int                gcount = 0;
    int                dcount = 0;
    int                m_ptr  = NREQ - 1;
    logic [NREQ-1:0]   prev_gnt = '0;
    logic [NREQ-1:0]   s_req;
    logic [NREQ*W-1:0] s_a;
    logic [NREQ*W-1:0] s_b;

    always @(posedge clk) begin
        s_req = req;
        s_a   = op_a;
        s_b   = op_b;
    end

    // Scoreboard: predict the winner when a grant appears, check the result at done.
    always @(negedge clk) begin
        cycle++;
        if (rst) begin
            sbq.delete();
            m_ptr    = NREQ - 1;
            prev_gnt = '0;
        end else begin
            if (gnt != 0 && prev_gnt == 0) begin
                int  w;
                sb_t e;
                w = -1;
                for (int i = 1; i <= NREQ; i++) begin
                    if (w < 0 && s_req[(m_ptr + i) % NREQ]) w = (m_ptr + i) % NREQ;
                end
                if (w < 0) w = 0;
                chk("grant_winner", 32'(gnt), 32'(1 << w));
                e.k   = w;
                e.exp = fault ? 8'h00 : (s_a[w*W +: W] ^ s_b[w*W +: W]);
                sbq.push_back(e);
                gorder.push_back(w);
                gtime.push_back(cycle);
                gcount++;
            end
            if (done != 0) begin
                if (sbq.size() == 0) begin
                    chk("done_unexpected", 32'(done), 32'(0));
                end else begin
                    sb_t e;
                    e = sbq.pop_front();
                    chk("done_bit", 32'(done), 32'(1 << e.k));
                    chk("sb_result", 32'(result), 32'(e.exp));
                    m_ptr = e.k;
                end
                dcount++;
            end
            prev_gnt = gnt;
        end
    end

    task automatic cyc();
        @(negedge clk);
        #1;
    endtask

    task automatic wait_done(input int target, input int budget, input string name);
        while (dcount < target && budget > 0) begin
            cyc();
            budget--;
        end
        chk(name, 32'(dcount >= target), 32'(1));
    endtask

    task automatic wait_grant(input int target, input int budget, input string name);
        while (gcount < target && budget > 0) begin
            cyc();
            budget--;
        end
        chk(name, 32'(gcount >= target), 32'(1));
    endtask

    task automatic wait_idle(input int budget);
        while (busy && budget > 0) begin
            cyc();
            budget--;
        end
        chk("idle_timeout", 32'(busy), 32'(0));
        cyc();
    endtask

    typedef struct {
        logic       flt;
        int         k;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] exp;
    } vec_t;

    vec_t vec[8];

    initial begin
        vec[0] = '{1'b0, 0, 8'hA5, 8'h3C, 8'h99};
        vec[1] = '{1'b0, 1, 8'hFF, 8'h0F, 8'hF0};
        vec[2] = '{1'b0, 2, 8'h12, 8'h34, 8'h26};
        vec[3] = '{1'b0, 3, 8'h00, 8'h00, 8'h00};
        vec[4] = '{1'b0, 2, 8'h80, 8'h01, 8'h81};
        vec[5] = '{1'b1, 1, 8'hA5, 8'h5A, 8'h00};
        vec[6] = '{1'b1, 3, 8'hFF, 8'h00, 8'h00};
        vec[7] = '{1'b0, 3, 8'hC3, 8'h0F, 8'hCC};

        // Reset state
        cyc();
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_result", 32'(result), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_xab", 32'({xa, xb}), 0);
        rst = 1'b0;
        cyc();

        // Single request with cycle-exact stream checks
        begin
            logic [7:0] a;
            logic [7:0] b;
            a = 8'hA5;
            b = 8'h3C;
            op_a[0 +: W] = a;
            op_b[0 +: W] = b;
            req = 4'b0001;
            for (int c = 1; c <= 10; c++) begin
                cyc();
                if (c == 1) req = 4'b0000;
                if (c <= 9) chk($sformatf("single_gnt_c%0d", c), 32'(gnt), 32'h1);
                else chk("single_gnt_off", 32'(gnt), 0);
                if (c <= 8) begin
                    chk($sformatf("single_xa_c%0d", c), 32'(xa), 32'(a[c-1]));
                    chk($sformatf("single_xb_c%0d", c), 32'(xb), 32'(b[c-1]));
                end
                if (c == 9) begin
                    chk("single_done", 32'(done), 32'h1);
                    chk("single_result", 32'(result), 32'h99);
                end else begin
                    chk($sformatf("single_nodone_c%0d", c), 32'(done), 0);
                end
            end
            wait_idle(20);
        end

        // Vector table
        for (int i = 0; i < 8; i++) begin
            int d0;
            d0 = dcount;
            fault = vec[i].flt;
            op_a[vec[i].k*W +: W] = vec[i].a;
            op_b[vec[i].k*W +: W] = vec[i].b;
            req = 4'(1 << vec[i].k);
            wait_done(d0 + 1, 30, "vec_timeout");
            chk($sformatf("vec%0d_done", i), 32'(done), 32'(1 << vec[i].k));
            chk($sformatf("vec%0d_result", i), 32'(result), 32'(vec[i].exp));
            req = '0;
            wait_idle(20);
        end
        fault = 1'b0;

        // Round-robin with all requests held
        begin
            int g0;
            g0 = gcount;
            op_a = 32'h11_22_33_44;
            op_b = 32'h0F_F0_AA_55;
            req  = 4'b1111;
            wait_grant(g0 + 5, 80, "rr_timeout");
            req = '0;
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("rr_order%0d", i), 32'(gorder[g0+i]), 32'(i % NREQ));
                if (i > 0)
                    chk($sformatf("rr_gap%0d", i), 32'(gtime[g0+i] - gtime[g0+i-1]), 32'(W + 2));
            end
            wait_idle(20);
        end

        // Fairness: requester 2 held, then 0 and 1 join
        begin
            int g0;
            int bud;
            g0  = gcount;
            req = 4'b0100;
            bud = 30;
            while (!done[2] && bud > 0) begin
                cyc();
                bud--;
            end
            chk("fair_first_done", 32'(done), 32'h4);
            req = 4'b0111;
            wait_grant(g0 + 4, 60, "fair_timeout");
            req = '0;
            chk("fair_order0", 32'(gorder[g0+1]), 0);
            chk("fair_order1", 32'(gorder[g0+2]), 1);
            chk("fair_order2", 32'(gorder[g0+3]), 2);
            wait_idle(20);
        end

        // Mid-service changes to req and operands
        begin
            int g0;
            int d0;
            g0 = gcount;
            d0 = dcount;
            op_a[1*W +: W] = 8'h6E;
            op_b[1*W +: W] = 8'hB1;
            req = 4'b0010;
            wait_grant(g0 + 1, 10, "mid_grant_timeout");
            cyc();
            cyc();
            cyc();
            req = '0;
            op_a[1*W +: W] = 8'h00;
            wait_done(d0 + 1, 20, "mid_timeout");
            chk("mid_done", 32'(done), 32'h2);
            chk("mid_result", 32'(result), 32'hDF);
            wait_idle(20);
        end

        // Reset in the middle of a service
        begin
            int g0;
            g0 = gcount;
            req = 4'b1000;
            wait_grant(g0 + 1, 10, "rstmid_grant_timeout");
            for (int c = 2; c <= 5; c++) cyc();
            rst = 1'b1;
            #1;
            chk("rstmid_gnt", 32'(gnt), 0);
            chk("rstmid_done", 32'(done), 0);
            chk("rstmid_busy", 32'(busy), 0);
            chk("rstmid_xab", 32'({xa, xb}), 0);
            chk("rstmid_result", 32'(result), 0);
            req = 4'b0010;
            cyc();
            rst = 1'b0;
            g0 = gcount;
            wait_grant(g0 + 1, 10, "rstrel_grant_timeout");
            chk("rstrel_gnt", 32'(gnt), 32'h2);
            req = '0;
            wait_idle(20);
            rst = 1'b1;
            req = 4'b0011;
            cyc();
            rst = 1'b0;
            g0 = gcount;
            wait_grant(g0 + 1, 10, "rstrel2_grant_timeout");
            chk("rstrel2_gnt", 32'(gnt), 32'h1);
            req = '0;
            wait_idle(20);
        end

        // Stuck-at-0 cell
        begin
            int d0;
            fault = 1'b1;
            op_a = 32'hDEAD_BEEF;
            op_b = 32'h1234_5678;
            req  = 4'b1111;
            d0   = dcount;
            wait_done(d0 + 4, 60, "stuck_timeout");
            req = '0;
            chk("stuck_result", 32'(result), 0);
            wait_idle(20);
            fault = 1'b0;
        end

        // Randomized operations with a correct cell
        for (int n = 0; n < 1000; n++) begin
            int d0;
            d0   = dcount;
            req  = 4'($urandom_range(1, 15));
            op_a = $urandom;
            op_b = $urandom;
            wait_done(d0 + 1, 30, "rand_timeout");
        end
        req = '0;
        wait_idle(20);
        chk("sb_drained", 32'(sbq.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
